// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM state encoding and baud divisor helper.
// Intended for reuse by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the transmitter; head entry is presented combinationally on dout.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic                 do_push, do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Guard locally so a careless caller cannot corrupt the pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed from a small byte FIFO with a valid/ready handshake.
// The serial line comes straight from a flop and idles high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned BW  = $clog2(CPB);
  localparam logic [BW-1:0] BaudLast = BW'(CPB - 1);
  localparam logic [BW-1:0] BaudOne  = BW'(1);
  localparam logic [2:0]    BitLast  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    BitOne   = 3'd1;

  uart_state_e          state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 baud_last;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (tx_valid),
    .pop  (fifo_pop),
    .din  (tx_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign tx_ready  = !fifo_full;
  assign tx        = tx_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;
  assign baud_last = (baud_q == BaudLast);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BaudOne;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_q == BitLast) state_d = StStop;
          else                  bit_d   = bit_q + BitOne;
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so the stop bit is exactly one bit time.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is decoded from the next state so tx can be registered without a cycle of lag.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 4 clocks per bit: frame tables, a line decoder with a
// byte scoreboard, and hand-written sequences for back-to-back, full FIFO and reset cases.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int decoded  = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         in_frame;

  uart_tx #(
    .CLK_FREQ  (16),
    .BAUD      (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  // Line decoder: detects a falling edge, samples mid-bit and checks bytes in order against
  // everything the handshake accepted.
  initial begin
    bit         prev_tx;
    int         pos;
    int         k;
    logic [7:0] rx_byte;
    logic [7:0] want;
    prev_tx  = 1'b1;
    in_frame = 1'b0;
    pos      = 0;
    rx_byte  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 1'b0;
        exp_q.delete();
        prev_tx = 1'b1;
      end else begin
        if (!in_frame) begin
          if (prev_tx && tx === 1'b0) begin
            in_frame = 1'b1;
            pos      = 0;
            start_q.push_back(edge_cnt);
          end
        end else begin
          pos++;
        end
        if (in_frame && (pos % 4) == 2) begin
          k = pos / 4;
          if (k == 0) begin
            check("start_bit", tx, 1'b0);
          end else if (k <= 8) begin
            rx_byte[k-1] = tx;
          end else begin
            check("stop_bit", tx, 1'b1);
            in_frame = 1'b0;
            check("frame_was_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
              want = exp_q.pop_front();
              check("decoded_byte", rx_byte, want);
            end
            decoded++;
          end
        end
        if (tx_valid && tx_ready) exp_q.push_back(tx_data);
        prev_tx = tx;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte and hold it until accepted; returns the accepting edge number.
  task automatic send(input logic [7:0] b, output int acc_edge);
    bit acc;
    bit rdy;
    acc      = 1'b0;
    tx_valid = 1'b1;
    tx_data  = b;
    for (int w = 0; w < 400 && !acc; w++) begin
      rdy = tx_ready;
      tick();
      if (rdy) acc = 1'b1;
    end
    tx_valid = 1'b0;
    acc_edge = edge_cnt;
    check("accepted", acc, 1'b1);
  endtask

  task automatic drain(input int limit, output int fall_edge);
    bit done;
    done      = 1'b0;
    fall_edge = -1;
    for (int c = 0; c < limit && !done; c++) begin
      tick();
      if (!busy && fall_edge < 0) fall_edge = edge_cnt;
      if (!busy && !in_frame && exp_q.size() == 0) done = 1'b1;
    end
    check("drained", done, 1'b1);
  endtask

  task automatic send_check(input logic [7:0] b, input logic [9:0] frame);
    int e;
    send(b, e);
    check("tx_high_on_accept", tx, 1'b1);
    check("busy_on_accept", busy, 1'b1);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("frame_bit", tx, frame[i/4]);
    end
    tick();
    check("idle_tx_after_frame", tx, 1'b1);
    check("idle_busy_after_frame", busy, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   e[6];
    int   fall;
    int   d0;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h81, 10'b1_10000001_0};
    vecs[4] = '{8'h7E, 10'b1_01111110_0};
    vecs[5] = '{8'h3C, 10'b1_00111100_0};
    vecs[6] = '{8'h6A, 10'b1_01101010_0};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_tx", tx, 1'b1);
    check("reset_ready", tx_ready, 1'b1);
    check("reset_busy", busy, 1'b0);

    // Idle line
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
    end

    // Single-frame table
    for (int v = 0; v < 7; v++) send_check(vecs[v].data, vecs[v].frame);

    // Back-to-back: three pushes on consecutive edges, no idle gap between frames
    start_q.delete();
    send(8'h00, e[0]);
    send(8'hFF, e[1]);
    send(8'h55, e[2]);
    check("b2b_consecutive_accept", e[2] - e[0], 2);
    drain(400, fall);
    check("b2b_frame_count", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("b2b_first_start", start_q[0] - e[0], 1);
      check("b2b_gap1", start_q[1] - start_q[0], 40);
      check("b2b_gap2", start_q[2] - start_q[1], 40);
    end
    check("b2b_total_cycles", fall - (e[0] + 1), 120);

    // Full FIFO with held valid; the sixth byte waits for space
    d0 = decoded;
    for (int i = 0; i < 6; i++) begin
      b = (i == 5) ? 8'h3C : 8'($urandom);
      send(b, e[i]);
      if (i == 4) check("ready_low_when_full", tx_ready, 1'b0);
    end
    check("full_five_consecutive", e[4] - e[0], 4);
    check("full_held_accept_edge", e[5] - e[0], 42);
    drain(600, fall);
    check("full_sent_once_each", decoded - d0, 6);

    // Reset in the middle of d3 of 0x81
    send(8'h81, e[0]);
    for (int i = 0; i < 18; i++) tick();
    check("pre_reset_d3", tx, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_tx", tx, 1'b1);
    check("midreset_busy", busy, 1'b0);
    check("midreset_ready", tx_ready, 1'b1);
    d0 = decoded;
    send_check(8'h7E, vecs[4].frame);
    check("after_reset_one_frame", decoded - d0, 1);

    // Randomized traffic against the scoreboard
    d0 = decoded;
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = ($urandom_range(0, 7) == 0) ? 45 : int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      send(8'($urandom), e[0]);
    end
    drain(24 * 40 + 400, fall);
    check("random_frame_count", decoded - d0, 24);
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_tx", tx, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
